// File: rtl/shot_pkg.sv
// Shared types and constants for the shot tracer: FSM states, playfield width
// and the width used for overflow-safe step arithmetic.
package shot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [4:0] X_MAX  = 5'd31;
    localparam int         STEP_W = 6;

endpackage

// File: rtl/shot_enff.sv
// Enable flop used for every register of the tracer: async active-low clear to
// zero, load only when the game tick enable is high.
module shot_enff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/shot_step.sv
// Combinational next-position calculator for one flight tick.
// SHOT_BOUNCE_EN selects reflecting walls; otherwise walls clamp the column.
module shot_step
    import shot_pkg::*;
#(
    parameter logic [4:0] Y_MAX = 5'd31
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [4:0] run,
    input  logic [4:0] rise,
    input  logic       dir,
    output logic [4:0] x_next,
    output logic [4:0] y_next,
    output logic       dir_next,
    output logic       top,
    output logic       wall
);

    logic [STEP_W-1:0] x_w;
    logic [STEP_W-1:0] run_w;
    logic [STEP_W-1:0] rise_w;
    logic [STEP_W-1:0] y_sum;
    logic [STEP_W-1:0] x_sum;

`ifdef SHOT_BOUNCE_EN
    localparam logic [STEP_W-1:0] MIRROR_HI = {X_MAX, 1'b0};
`endif

    assign x_w    = {1'b0, x};
    assign run_w  = {1'b0, run};
    // A zero rise would never reach the top, so it is promoted to one.
    assign rise_w = (rise == 5'd0) ? 6'd1 : {1'b0, rise};
    assign y_sum  = {1'b0, y} + rise_w;
    assign x_sum  = x_w + run_w;

    assign top    = (y_sum >= {1'b0, Y_MAX});
    assign y_next = top ? Y_MAX : y_sum[4:0];

    always_comb begin
        x_next   = x;
        dir_next = dir;
        wall     = 1'b0;
        if (run != 5'd0) begin
            if (dir) begin
                if (x_sum >= {1'b0, X_MAX}) begin
                    wall = 1'b1;
`ifdef SHOT_BOUNCE_EN
                    x_next   = 5'(MIRROR_HI - x_sum);
                    dir_next = 1'b0;
`else
                    x_next   = X_MAX;
`endif
                end else begin
                    x_next = x_sum[4:0];
                end
            end else begin
                // Moving left: reaching or passing column 0 happens when run >= x.
                if (run_w >= x_w) begin
                    wall = 1'b1;
`ifdef SHOT_BOUNCE_EN
                    x_next   = 5'(run_w - x_w);
                    dir_next = 1'b1;
`else
                    x_next   = 5'd0;
`endif
                end else begin
                    x_next = 5'(x_w - run_w);
                end
            end
        end
    end

endmodule

// File: rtl/shot_tracer.sv
// Shot tracer top: launch, per-tick flight and one-tick DONE hold.
// SHOT_BOUNCE_EN makes walls reflect the shot instead of ending the flight.
module shot_tracer
    import shot_pkg::*;
#(
    parameter logic [4:0] Y_MAX = 5'd31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       fire,
    input  logic [4:0] x_pos,
    input  logic [4:0] run,
    input  logic [4:0] rise,
    input  logic       dir,
    output logic [4:0] shot_x,
    output logic [4:0] shot_y,
    output logic       active,
    output logic       hit_top,
    output logic       wall_hit
);

`ifdef SHOT_BOUNCE_EN
    localparam bit WALL_STOPS = 1'b0;
`else
    localparam bit WALL_STOPS = 1'b1;
`endif

    state_e     state_q, state_d;
    logic [1:0] state_bits_q;
    logic [4:0] x_q, x_d, y_q, y_d, run_q, run_d, rise_q, rise_d;
    logic       dir_q, dir_d, hit_q, hit_d, wall_q, wall_d;

    logic [4:0] step_x, step_y;
    logic       step_dir, step_top, step_wall;

    shot_step #(.Y_MAX(Y_MAX)) u_step (
        .x        (x_q),
        .y        (y_q),
        .run      (run_q),
        .rise     (rise_q),
        .dir      (dir_q),
        .x_next   (step_x),
        .y_next   (step_y),
        .dir_next (step_dir),
        .top      (step_top),
        .wall     (step_wall)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        run_d   = run_q;
        rise_d  = rise_q;
        dir_d   = dir_q;
        hit_d   = 1'b0;
        wall_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    run_d   = run;
                    rise_d  = rise;
                    dir_d   = dir;
                    x_d     = x_pos;
                    y_d     = 5'd0;
                    state_d = FLY;
                end
            end
            FLY: begin
                x_d    = step_x;
                y_d    = step_y;
                dir_d  = step_dir;
                hit_d  = step_top;
                wall_d = step_wall;
                if (step_top || (step_wall && WALL_STOPS)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    shot_enff #(.W(2)) u_state_ff (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(state_d), .q_o(state_bits_q));
    shot_enff #(.W(5)) u_x_ff     (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(x_d),     .q_o(x_q));
    shot_enff #(.W(5)) u_y_ff     (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(y_d),     .q_o(y_q));
    shot_enff #(.W(5)) u_run_ff   (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(run_d),   .q_o(run_q));
    shot_enff #(.W(5)) u_rise_ff  (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(rise_d),  .q_o(rise_q));
    shot_enff #(.W(1)) u_dir_ff   (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(dir_d),   .q_o(dir_q));
    shot_enff #(.W(1)) u_hit_ff   (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(hit_d),   .q_o(hit_q));
    shot_enff #(.W(1)) u_wall_ff  (.clk(clk), .rst_n(rst_n), .en_i(ena), .d_i(wall_d),  .q_o(wall_q));

    assign state_q  = state_e'(state_bits_q);
    assign shot_x   = x_q;
    assign shot_y   = y_q;
    assign active   = (state_q == FLY);
    assign hit_top  = hit_q;
    assign wall_hit = wall_q;

endmodule

// File: tb/tb_shot_tracer.sv
// Self-checking bench for shot_tracer: directed scenarios plus randomized ticks
// compared against an integer-arithmetic reference model (honours SHOT_BOUNCE_EN).
module tb_shot_tracer;

    logic       clk = 1'b0;
    logic       rst_n, ena, fire, dir;
    logic [4:0] x_pos, run, rise;
    logic [4:0] shot_x, shot_y;
    logic       active, hit_top, wall_hit;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: 0 idle, 1 flying, 2 done.
    int m_st, m_x, m_y, m_run, m_rise, m_dir;
    bit m_hit, m_wall;

    shot_tracer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .fire(fire), .x_pos(x_pos),
        .run(run), .rise(rise), .dir(dir), .shot_x(shot_x), .shot_y(shot_y),
        .active(active), .hit_top(hit_top), .wall_hit(wall_hit)
    );

    always #5 clk = ~clk;

    wire [12:0] dut_vec = {shot_x, shot_y, active, hit_top, wall_hit};

    function automatic void model_reset();
        m_st = 0; m_x = 0; m_y = 0; m_run = 0; m_rise = 0; m_dir = 0;
        m_hit = 0; m_wall = 0;
    endfunction

    function automatic void model_step();
        int r, nx, ny;
        bit stop;
        m_hit = 0;
        m_wall = 0;
        if (m_st == 0) begin
            if (fire) begin
                m_run = int'(run); m_rise = int'(rise); m_dir = int'(dir);
                m_x = int'(x_pos); m_y = 0; m_st = 1;
            end
        end else if (m_st == 1) begin
            stop = 0;
            r  = (m_rise == 0) ? 1 : m_rise;
            ny = m_y + r;
            nx = m_x;
            if (ny >= 31) begin ny = 31; m_hit = 1; stop = 1; end
            if (m_run != 0) begin
                nx = (m_dir != 0) ? m_x + m_run : m_x - m_run;
                if (nx <= 0 || nx >= 31) begin
                    m_wall = 1;
`ifdef SHOT_BOUNCE_EN
                    if (nx < 0) nx = -nx;
                    else if (nx > 31) nx = 62 - nx;
                    m_dir = (m_dir != 0) ? 0 : 1;
`else
                    nx = (nx <= 0) ? 0 : 31;
                    stop = 1;
`endif
                end
            end
            m_x = nx; m_y = ny;
            if (stop) m_st = 2;
        end else begin
            m_st = 0;
        end
    endfunction

    function automatic logic [12:0] model_vec();
        return {5'(m_x), 5'(m_y), (m_st == 1), m_hit, m_wall};
    endfunction

    task automatic tick(input bit e, input bit f);
        ena = e;
        fire = f;
        @(posedge clk);
        if (e) model_step();
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && m_st != 0; i++) tick(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; fire = 1'b0; dir = 1'b0;
        x_pos = 5'd0; run = 5'd0; rise = 5'd0;
        model_reset();
        #2;
        n_cmp++;
        if (dut_vec !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_state: got x=%0d y=%0d act=%b hit=%b wall=%b, want all 0",
                     shot_x, shot_y, active, hit_top, wall_hit);
        end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_vertical();
        logic [12:0] exp;
        x_pos = 5'd10; run = 5'd0; rise = 5'd1; dir = 1'b0;
        tick(1'b1, 1'b1);
        exp = {5'd10, 5'd0, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL vertical_launch: got %b want %b", dut_vec, exp);
        end
        for (int i = 1; i <= 31; i++) begin
            tick(1'b1, 1'b0);
            exp = {5'd10, 5'(i), (i < 31), (i == 31), 1'b0};
            n_cmp++;
            if (dut_vec !== exp) begin
                n_bad++; $display("FAIL vertical_tick%0d: got %b want %b", i, dut_vec, exp);
            end
        end
        tick(1'b1, 1'b1);
        exp = {5'd10, 5'd31, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL vertical_done_hold: got %b want %b", dut_vec, exp);
        end
        tick(1'b1, 1'b0);
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL vertical_idle_no_relaunch: got %b want %b", dut_vec, exp);
        end
        $display("vertical shot x=10 finished, hit_top seen on tick 31");
    endtask

    task automatic test_wall();
        logic [12:0] exp;
        x_pos = 5'd1; run = 5'd2; rise = 5'd1; dir = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
`ifdef SHOT_BOUNCE_EN
        exp = {5'd1, 5'd1, 1'b1, 1'b0, 1'b1};
`else
        exp = {5'd0, 5'd1, 1'b0, 1'b0, 1'b1};
`endif
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL wall_first_step: got %b want %b", dut_vec, exp);
        end
        tick(1'b1, 1'b0);
`ifdef SHOT_BOUNCE_EN
        exp = {5'd3, 5'd2, 1'b1, 1'b0, 1'b0};
`else
        exp = {5'd0, 5'd1, 1'b0, 1'b0, 1'b0};
`endif
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL wall_second_step: got %b want %b", dut_vec, exp);
        end
        drain();
        tick(1'b1, 1'b1);
        exp = {5'd1, 5'd0, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL wall_relaunch_from_idle: got %b want %b", dut_vec, exp);
        end
        drain();
        $display("wall shot x=1 run=2 dir=0 finished");
    endtask

    task automatic test_top_boundary();
        logic [12:0] exp;
        x_pos = 5'd20; run = 5'd0; rise = 5'd2; dir = 1'b1;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0);
        exp = {5'd20, 5'd30, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL top_at_30: got %b want %b", dut_vec, exp);
        end
        tick(1'b1, 1'b0);
        exp = {5'd20, 5'd31, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL top_saturate_31: got %b want %b", dut_vec, exp);
        end
        drain();
        $display("top boundary shot rise=2 finished at row 31");
    endtask

    task automatic test_ena_gaps();
        logic [12:0] prev;
        bit e;
        x_pos = 5'd5; run = 5'd1; rise = 5'd1; dir = 1'b1;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 120 && m_st == 1; i++) begin
            e = ($urandom_range(0, 2) != 0);
            prev = dut_vec;
            x_pos = 5'($urandom_range(0, 31));
            tick(e, 1'b1);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL gaps_model_t%0d: got %b want %b", i, dut_vec, model_vec());
            end
            if (!e) begin
                n_cmp++;
                if (dut_vec !== prev) begin
                    n_bad++; $display("FAIL gaps_frozen_t%0d: got %b want %b", i, dut_vec, prev);
                end
            end
        end
        drain();
        $display("ena-gap shot with fire held finished");
    endtask

    task automatic test_async_reset();
        logic [12:0] exp;
        x_pos = 5'd8; run = 5'd1; rise = 5'd1; dir = 1'b0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== 13'd0) begin
            n_bad++; $display("FAIL async_reset_immediate: got %b want 0", dut_vec);
        end
        ena = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (dut_vec !== 13'd0) begin
            n_bad++; $display("FAIL async_reset_held: got %b want 0", dut_vec);
        end
        #3 rst_n = 1'b1;
        tick(1'b1, 1'b1);
        exp = {5'd8, 5'd0, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++; $display("FAIL async_reset_relaunch: got %b want %b", dut_vec, exp);
        end
        drain();
        $display("mid-flight reset and relaunch finished");
    endtask

    task automatic test_random();
        bit e, f, launch;
        for (int t = 0; t < 2000; t++) begin
            x_pos = 5'($urandom_range(0, 31));
            run   = 5'($urandom_range(0, 4));
            rise  = 5'($urandom_range(0, 3));
            dir   = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 2) == 0);
            launch = (m_st == 0) && e && f;
            tick(e, f);
            if (launch)
                $display("random shot t=%0d x=%0d run=%0d rise=%0d dir=%0d", t, x_pos, run, rise, dir);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL random_t%0d: got %b want %b", t, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_wall();
        test_top_boundary();
        test_ena_gaps();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shot_tracer.md
SHOT_TRACER -- requirements
Module: shot_tracer

Interface
REQ-001 SHALL have parameter: Y_MAX, default 5'd31, meaning the top row at which a shot terminates.
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ena  input  1  game tick; state advances only in cycles where ena=1.
REQ-005 SHALL have port: fire  input  1  launch request, sampled only when ena=1.
REQ-006 SHALL have port: x_pos  input  5  shooter column, sampled at launch.
REQ-007 SHALL have port: run  input  5  horizontal step per tick (legal 0..2), sampled at launch.
REQ-008 SHALL have port: rise  input  5  vertical step per tick (legal 1..2), sampled at launch.
REQ-009 SHALL have port: dir  input  1  horizontal direction at launch; 0 = toward column 0, 1 = toward column 31.
REQ-010 SHALL have port: shot_x  output  5  current shot column.
REQ-011 SHALL have port: shot_y  output  5  current shot row; 0 = shooter row.
REQ-012 SHALL have port: active  output  1  high while in FLY state.
REQ-013 SHALL have port: hit_top  output  1  one-cycle pulse when the shot reaches Y_MAX.
REQ-014 SHALL have port: wall_hit  output  1  one-cycle pulse when the shot reaches column 0 or 31 with horizontal motion.

Function
REQ-015 SHALL implement states IDLE, FLY and DONE; no state, output or latched value changes in a cycle where ena=0.
REQ-016 In IDLE with ena=1 and fire=1, SHALL latch run, rise and dir, set shot_x=x_pos and shot_y=0, and enter FLY; active rises on the next edge (1-tick launch latency).
REQ-017 SHALL ignore fire in FLY and DONE; there is no queueing of launch requests.
REQ-018 In FLY with ena=1, SHALL compute y_next = shot_y + rise in 6 bits; if y_next >= Y_MAX, it SHALL set shot_y=Y_MAX, pulse hit_top, and enter DONE.
REQ-019 In FLY with ena=1, SHALL move the column by the latched run in the latched direction, computed in 6-bit signed-safe arithmetic.
REQ-020 A latched run of 0 SHALL give purely vertical flight and SHALL never assert wall_hit.
REQ-021 If the horizontal step crosses or lands on column 0 or 31, the wall rule of REQ-030/REQ-031 SHALL apply.
REQ-022 When the top rule and the wall rule fire in the same tick, SHALL apply both: hit_top and wall_hit pulse together and the state goes to DONE.
REQ-023 DONE SHALL hold shot_x and shot_y for exactly one ena tick, then return to IDLE.
REQ-024 In IDLE, shot_x and shot_y SHALL retain their last values; fire in the DONE tick SHALL be ignored.
REQ-025 Illegal run > 2 or rise = 0 SHALL not hang the block: rise = 0 is treated as 1, and the column is saturated to the range 0..31.

Reset
REQ-026 On rst_n=0, SHALL immediately, independent of clk, set state=IDLE, shot_x=0, shot_y=0, active=0, hit_top=0, wall_hit=0, latched run/rise=0 and latched dir=0.
REQ-027 Reset asserted mid-flight SHALL abort the shot with no hit_top or wall_hit pulse.
REQ-028 The first launch after reset deassertion SHALL be accepted on the first ena=1 tick with fire=1.

Configuration
REQ-029 Macro SHOT_BOUNCE_EN SHALL select the wall behaviour.
REQ-030 With SHOT_BOUNCE_EN defined, a step past a wall SHALL reflect: the new column is the mirrored overshoot (below 0: -x; above 31: 62-x), the latched dir toggles, wall_hit pulses, and FLY continues unless the top rule fires.
REQ-031 Without SHOT_BOUNCE_EN, a step reaching or passing a wall SHALL clamp the column to 0 or 31, pulse wall_hit, and enter DONE.

Structure
REQ-032 Package shot_pkg SHALL hold the state enum (IDLE, FLY, DONE), X_MAX=31 and the 6-bit step-width constant.
REQ-033 Sub-module shot_step SHALL be a combinational next-position calculator: inputs x, y, run, rise and dir; outputs x_next, y_next, dir_next, top and wall.
REQ-034 All registers SHALL use the codebase enable-flop with ena as the enable.

Verification
REQ-035 SHALL test: x_pos=10, run=0, rise=1, dir=0, fire -> shot_x stays 10, shot_y 0..31 over 31 ticks, hit_top on tick 31, IDLE after DONE.
REQ-036 SHALL test: x_pos=1, run=2, rise=1, dir=0 with SHOT_BOUNCE_EN -> next shot_x=1, dir=1, wall_hit pulse, shot_y=1.
REQ-037 SHALL test: same stimulus without SHOT_BOUNCE_EN -> shot_x=0, wall_hit pulse, DONE, then IDLE.
REQ-038 SHALL test: shot_y=30, rise=2 -> shot_y=31 and hit_top, not a wrap to 0.
REQ-039 SHALL test: fire held high during FLY, and ena=0 gaps -> no relaunch, and position frozen during the gaps.
REQ-040 SHALL test: rst_n pulsed low mid-flight between clk edges -> outputs 0 at once, no pulses, relaunch accepted afterwards.
